mem_access_ctrl: RTL

- Sequences one data-memory transaction per load/store issued by the MEM stage onto a single-outstanding req/ack data bus.
- Consumes the per-instruction control produced in ID (read/write/sign flags, byte select, write data) plus the effective address.
- Performs byte-lane alignment, misalignment detection, load extraction with sign/zero extension, and bus timeout.
- Holds the pipeline via stall_req until the access completes.

---
 rtl/mem_access_ctrl_pkg.sv | 25 ++
 rtl/mem_lane_align.sv | 30 +++
 rtl/mem_access_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared bus widths and access-size encodings for the MEM-stage data path.
// The size constants are also consumed by the ID-stage control generator.
package mem_access_ctrl_pkg;

   localparam int DATA_BUS    = 32;
   localparam int ADDR_BUS    = 32;
   localparam int MEM_SEL_BUS = 4;

   localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_BYTE = 4'b0001;
   localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_HALF = 4'b0011;
   localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_WORD = 4'b1111;

   // Halves must sit on even addresses, words on multiples of four.
   function automatic logic sel_misaligned(input logic [MEM_SEL_BUS-1:0] sel,
                                           input logic [1:0]             offset);
      logic mis;
      case (sel)
         MEM_SEL_HALF: mis = offset[0];
         MEM_SEL_WORD: mis = (offset != 2'b00);
         default:      mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store-side shift into bus lanes and
// load-side extraction with sign/zero extension.
module mem_lane_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [MEM_SEL_BUS-1:0] sel,
   input  logic [1:0]             offset,
   input  logic                   sign,
   input  logic [DATA_BUS-1:0]    wdata,
   input  logic [DATA_BUS-1:0]    rdata,
   output logic [MEM_SEL_BUS-1:0] byte_en,
   output logic [DATA_BUS-1:0]    wdata_lane,
   output logic [DATA_BUS-1:0]    load_word
);

   logic [DATA_BUS-1:0] shifted_s;

   // lane shift by byte offset, then size-dependent extension of the low bytes
   always_comb begin
      byte_en    = sel << offset;
      wdata_lane = wdata << {offset, 3'b000};
      shifted_s  = rdata >> {offset, 3'b000};
      case (sel)
         MEM_SEL_BYTE: load_word = {{24{sign & shifted_s[7]}}, shifted_s[7:0]};
         MEM_SEL_HALF: load_word = {{16{sign & shifted_s[15]}}, shifted_s[15:0]};
         default:      load_word = shifted_s;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: one load/store per instruction onto a
// single-outstanding req/ack bus, with misalignment refusal and bus timeout.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 8
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_read_flag,
   input  logic                   mem_write_flag,
   input  logic                   mem_sign_flag,
   input  logic [MEM_SEL_BUS-1:0] mem_sel,
   input  logic [ADDR_BUS-1:0]    mem_addr,
   input  logic [DATA_BUS-1:0]    mem_write_data,
   input  logic                   flush,
   output logic                   stall_req,
   output logic [DATA_BUS-1:0]    load_data,
   output logic                   load_valid,
   output logic                   misalign,
   output logic                   bus_error,
   output logic                   bus_req,
   output logic                   bus_we,
   output logic [ADDR_BUS-1:0]    bus_addr,
   output logic [MEM_SEL_BUS-1:0] bus_byte_en,
   output logic [DATA_BUS-1:0]    bus_wdata,
   input  logic                   bus_ack,
   input  logic [DATA_BUS-1:0]    bus_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   localparam bit                   TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_e                 state_r, state_nx;
   logic [CNT_WIDTH-1:0]   cnt_r;
   logic                   kill_r, we_r, sign_r;
   logic [MEM_SEL_BUS-1:0] sel_r, be_r;
   logic [1:0]             off_r;
   logic [ADDR_BUS-1:0]    addr_r;
   logic [DATA_BUS-1:0]    wdata_r, load_data_r;

   logic                   access_s, misalign_s, start_s;
   logic [MEM_SEL_BUS-1:0] lane_sel_s, lane_be_s;
   logic [1:0]             lane_off_s;
   logic                   lane_sign_s;
   logic [DATA_BUS-1:0]    lane_wdata_s, lane_load_s;

   // The aligner sees the live request in IDLE and the captured one afterwards.
   always_comb begin
      if (state_r == ST_IDLE) begin
         lane_sel_s  = mem_sel;
         lane_off_s  = mem_addr[1:0];
         lane_sign_s = mem_sign_flag;
      end else begin
         lane_sel_s  = sel_r;
         lane_off_s  = off_r;
         lane_sign_s = sign_r;
      end
   end

   mem_lane_align u_lane (
      .sel        (lane_sel_s),
      .offset     (lane_off_s),
      .sign       (lane_sign_s),
      .wdata      (mem_write_data),
      .rdata      (bus_rdata),
      .byte_en    (lane_be_s),
      .wdata_lane (lane_wdata_s),
      .load_word  (lane_load_s)
   );

   // IDLE request decode; rst gates it so every output reads 0 during reset
   always_comb begin
      access_s   = !rst && (state_r == ST_IDLE) && !flush &&
                   (mem_read_flag || mem_write_flag) && (mem_sel != 4'b0000);
      misalign_s = access_s && sel_misaligned(mem_sel, mem_addr[1:0]);
      start_s    = access_s && !misalign_s;
   end

   // next-state and output decode
   always_comb begin
      state_nx    = state_r;
      stall_req   = 1'b0;
      misalign    = 1'b0;
      load_valid  = 1'b0;
      bus_error   = 1'b0;
      bus_req     = 1'b0;
      bus_we      = 1'b0;
      bus_addr    = '0;
      bus_byte_en = '0;
      bus_wdata   = '0;
      case (state_r)
         ST_IDLE: begin
            misalign  = misalign_s;
            stall_req = start_s;
            if (start_s) begin
               state_nx = ST_REQ;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_REQ: begin
            stall_req   = 1'b1;
            bus_req     = 1'b1;
            bus_we      = we_r;
            bus_addr    = addr_r;
            bus_byte_en = be_r;
            bus_wdata   = wdata_r;
            if (bus_ack) begin
               state_nx = ST_DONE;
            end else if (TIMEOUT_EN && (cnt_r == CNT_LAST)) begin
               state_nx = ST_ERR;
            end else begin
               state_nx = ST_REQ;
            end
         end
         ST_DONE: begin
            load_valid = !we_r && !kill_r && !flush;
            state_nx   = ST_IDLE;
         end
         ST_ERR: begin
            bus_error = !kill_r && !flush;
            state_nx  = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // state register, request capture, timeout counter, kill flag, load result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         kill_r      <= 1'b0;
         we_r        <= 1'b0;
         sign_r      <= 1'b0;
         sel_r       <= '0;
         off_r       <= 2'b00;
         be_r        <= '0;
         addr_r      <= '0;
         wdata_r     <= '0;
         load_data_r <= '0;
      end else begin
         state_r <= state_nx;
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  we_r    <= mem_write_flag;
                  sign_r  <= mem_sign_flag;
                  sel_r   <= mem_sel;
                  off_r   <= mem_addr[1:0];
                  be_r    <= lane_be_s;
                  addr_r  <= {mem_addr[ADDR_BUS-1:2], 2'b00};
                  wdata_r <= lane_wdata_s;
                  kill_r  <= 1'b0;
                  cnt_r   <= '0;
               end
            end
            ST_REQ: begin
               cnt_r <= cnt_r + CNT_WIDTH'(1);
               if (flush) begin
                  kill_r <= 1'b1;
               end
               // a flushed load still captures its data; only the valid pulse is withheld
               if (bus_ack && !we_r) begin
                  load_data_r <= lane_load_s;
               end
            end
            default: ;
         endcase
      end
   end

   assign load_data = load_data_r;

endmodule
